// File: rtl/dcache_responder.sv
// Direct-mapped, one-word-per-frame, write-back/write-allocate data cache responder.
// Hits complete combinationally; misses go through a single-word memory port; halt flushes dirty frames.
module dcache_responder #(
   parameter int          NSETS       = 16,
   parameter logic [31:0] HITCNT_ADDR = 32'h0000_3100
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        dmemREN,
   input  logic        dmemWEN,
   input  logic [31:0] dmemaddr,
   input  logic [31:0] dmemstore,
   input  logic        halt,
   output logic        dhit,
   output logic [31:0] dmemload,
   output logic        flushed,
   output logic        dREN,
   output logic        dWEN,
   output logic [31:0] daddr,
   output logic [31:0] dstore,
   input  logic        dwait,
   input  logic [31:0] dload
);

   localparam int IW = $clog2(NSETS);
   localparam int TW = 30 - IW;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WB       = 3'd1,
      FETCH    = 3'd2,
      FLUSH    = 3'd3,
      FLUSH_WB = 3'd4,
      HITCNT   = 3'd5,
      DONE     = 3'd6
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     fidx_q, fidx_d;
   logic [31:0]       hitcnt_q;
   logic              missed_q;
   logic [NSETS-1:0]  valid_q;
   logic [NSETS-1:0]  dirty_q;
   logic [TW-1:0]     tag_q  [NSETS];
   logic [31:0]       data_q [NSETS];

   logic [IW-1:0]     req_idx_s;
   logic [TW-1:0]     req_tag_s;
   logic              idle_req_s;
   logic              hit_s;
   logic              last_s;
   logic              unused_s;

   assign req_idx_s  = dmemaddr[IW+1:2];
   assign req_tag_s  = dmemaddr[31:IW+2];
   assign unused_s   = ^dmemaddr[1:0];
   // halt outranks any request, so a request only counts in IDLE without halt
   assign idle_req_s = (state_q == IDLE) && !halt && (dmemREN || dmemWEN);
   assign hit_s      = idle_req_s && valid_q[req_idx_s] && (tag_q[req_idx_s] == req_tag_s);
   assign last_s     = (fidx_q == IW'(NSETS - 1));

   // State register, flush index, hit counter
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         fidx_q   <= '0;
         hitcnt_q <= 32'd0;
         missed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         fidx_q  <= fidx_d;
         if (hit_s) begin
            if (!missed_q) hitcnt_q <= hitcnt_q + 32'd1;
            missed_q <= 1'b0;
         end else if (idle_req_s) begin
            missed_q <= 1'b1;
         end
      end
   end

   // Frame valid/dirty bits
   always_ff @(posedge CLK) begin
      if (RST) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         case (state_q)
            IDLE:     if (hit_s && dmemWEN) dirty_q[req_idx_s] <= 1'b1;
            WB:       if (!dwait) dirty_q[req_idx_s] <= 1'b0;
            FETCH: begin
               if (!dwait) begin
                  valid_q[req_idx_s] <= 1'b1;
                  dirty_q[req_idx_s] <= 1'b0;
               end
            end
            FLUSH_WB: if (!dwait) dirty_q[fidx_q] <= 1'b0;
            default:  ;
         endcase
      end
   end

   // Frame tag/data storage (no reset; qualified by valid)
   always_ff @(posedge CLK) begin
      if (hit_s && dmemWEN) begin
         data_q[req_idx_s] <= dmemstore;
      end else if ((state_q == FETCH) && !dwait && !RST) begin
         data_q[req_idx_s] <= dload;
         tag_q[req_idx_s]  <= req_tag_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      fidx_d  = fidx_q;
      case (state_q)
         IDLE: begin
            if (halt) begin
               state_d = FLUSH;
               fidx_d  = '0;
            end else if (idle_req_s && !hit_s) begin
               state_d = (valid_q[req_idx_s] && dirty_q[req_idx_s]) ? WB : FETCH;
            end
         end
         WB:       if (!dwait) state_d = FETCH;
         FETCH:    if (!dwait) state_d = IDLE;
         FLUSH: begin
            if (valid_q[fidx_q] && dirty_q[fidx_q]) state_d = FLUSH_WB;
            else if (last_s)                        state_d = HITCNT;
            else                                    fidx_d  = fidx_q + IW'(1);
         end
         FLUSH_WB: begin
            if (!dwait) begin
               if (last_s) begin
                  state_d = HITCNT;
               end else begin
                  state_d = FLUSH;
                  fidx_d  = fidx_q + IW'(1);
               end
            end
         end
         HITCNT:   if (!dwait) state_d = DONE;
         DONE:     state_d = DONE;
         default:  state_d = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      dhit     = hit_s;
      dmemload = (hit_s && dmemREN) ? data_q[req_idx_s] : 32'd0;
      flushed  = (state_q == DONE);
      dREN     = 1'b0;
      dWEN     = 1'b0;
      daddr    = 32'd0;
      dstore   = 32'd0;
      case (state_q)
         WB: begin
            dWEN   = 1'b1;
            daddr  = {tag_q[req_idx_s], req_idx_s, 2'b00};
            dstore = data_q[req_idx_s];
         end
         FETCH: begin
            dREN  = 1'b1;
            daddr = {dmemaddr[31:2], 2'b00};
         end
         FLUSH_WB: begin
            dWEN   = 1'b1;
            daddr  = {tag_q[fidx_q], fidx_q, 2'b00};
            dstore = data_q[fidx_q];
         end
         HITCNT: begin
            dWEN   = 1'b1;
            daddr  = HITCNT_ADDR;
            dstore = hitcnt_q;
         end
         default: ;
      endcase
   end

endmodule
